riscv_wb_port_arbiter: RTL and testbench

//  Shares the register file's single write port (rd_addr/rd_data/rd_we) among NUM_REQ writeback requesters.

---
 rtl/riscv_wb_port_arbiter_if.sv | 29 ++
 rtl/riscv_wb_port_arbiter.sv | 90 +++++++++
 tb/tb_riscv_wb_port_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_wb_port_arbiter_if.sv
// Writeback port bus: requester handshakes, register-file write port and
// pending-write scoreboard controls/status grouped for the arbiter.
interface riscv_wb_port_arbiter_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = 32
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [5*NUM_REQ-1:0]    req_addr;
  logic [XLEN*NUM_REQ-1:0] req_data;
  logic                    wb_stall;
  logic                    rd_we;
  logic [4:0]              rd_addr;
  logic [XLEN-1:0]         rd_data;
  logic                    sb_set_en;
  logic [4:0]              sb_set_addr;
  logic                    sb_flush;
  logic [31:0]             busy;

  modport master (
    output req_valid, req_addr, req_data, wb_stall, sb_set_en, sb_set_addr, sb_flush,
    input  req_ready, rd_we, rd_addr, rd_data, busy
  );

  modport slave (
    input  req_valid, req_addr, req_data, wb_stall, sb_set_en, sb_set_addr, sb_flush,
    output req_ready, rd_we, rd_addr, rd_data, busy
  );
endinterface

// File: rtl/riscv_wb_port_arbiter.sv
// Round-robin arbiter sharing the register file write port among NUM_REQ
// writeback requesters, with a registered write stage and RAW scoreboard.
module riscv_wb_port_arbiter #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  riscv_wb_port_arbiter_if.slave  bus
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   gnt_idx;
  logic            gnt_found;
  logic            xfer;
  logic [4:0]      gnt_addr;
  logic [XLEN-1:0] gnt_data;
  logic            rd_we_q;
  logic [4:0]      rd_addr_q;
  logic [XLEN-1:0] rd_data_q;
  logic [31:0]     busy_q, busy_d;

  function automatic int unsigned wrap_idx(input int unsigned v);
    return (v >= NUM_REQ) ? v - NUM_REQ : v;
  endfunction

  // First valid requester at or after the pointer, modulo NUM_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && bus.req_valid[wrap_idx(32'(rr_ptr_q) + k)]) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(wrap_idx(32'(rr_ptr_q) + k));
      end
    end
  end

  assign xfer     = gnt_found & ~bus.wb_stall & rst_n;
  assign gnt_addr = bus.req_addr[32'(gnt_idx) * 5 +: 5];
  assign gnt_data = bus.req_data[32'(gnt_idx) * XLEN +: XLEN];

  assign bus.req_ready = xfer ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Newly issued producer (set) outranks both flush and a completing write.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned r = 1; r < 32; r++) begin
      if (bus.sb_set_en && (bus.sb_set_addr == 5'(r))) begin
        busy_d[r] = 1'b1;
      end else if (bus.sb_flush || (xfer && (gnt_addr == 5'(r)))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      busy_q    <= '0;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      rd_we_q  <= xfer && (gnt_addr != '0);
      if (xfer && (gnt_addr != '0)) begin
        rd_addr_q <= gnt_addr;
        rd_data_q <= gnt_data;
      end
    end
  end

  assign bus.rd_we   = rd_we_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_riscv_wb_port_arbiter.sv
// Directed bench for riscv_wb_port_arbiter: expected writes are queued when a
// grant is expected and checked against the registered port one cycle later.
module tb_riscv_wb_port_arbiter;

  logic clk;
  logic rst_n;

  riscv_wb_port_arbiter_if #(.NUM_REQ(3), .XLEN(32)) bus ();

  riscv_wb_port_arbiter #(.NUM_REQ(3), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        we;
    logic        chk;
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  logic [4:0]  ra[3];
  logic [31:0] rdv[3];
  logic        last_ok;
  logic [4:0]  last_a;
  logic [31:0] last_d;
  logic [31:0] exp_b;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    ra[i]  = a;
    rdv[i] = d;
    bus.req_addr[5*i +: 5]   = a;
    bus.req_data[32*i +: 32] = d;
  endtask

  // Inputs are already applied (posedge+1); checks ready mid-cycle, then the
  // registered port and busy vector after the following edge.
  task automatic do_cycle(input string tag, input logic [2:0] exp_rdy, input logic [31:0] exp_busy);
    exp_t e;
    #2;
    chk({tag, ".ready"}, 64'(bus.req_ready), 64'(exp_rdy));
    e.we   = 1'b0;
    e.chk  = last_ok;
    e.addr = last_a;
    e.data = last_d;
    for (int i = 0; i < 3; i++) begin
      if (exp_rdy[i]) begin
        if (ra[i] != 5'd0) begin
          e.we = 1'b1; e.chk = 1'b1; e.addr = ra[i]; e.data = rdv[i];
          last_ok = 1'b1; last_a = ra[i]; last_d = rdv[i];
        end else begin
          e.chk = 1'b0;
          last_ok = 1'b0;
        end
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      chk({tag, ".qempty"}, 64'(1), 64'(0));
    end else begin
      e = q.pop_front();
      chk({tag, ".rd_we"}, 64'(bus.rd_we), 64'(e.we));
      if (e.chk) begin
        chk({tag, ".rd_addr"}, 64'(bus.rd_addr), 64'(e.addr));
        chk({tag, ".rd_data"}, 64'(bus.rd_data), 64'(e.data));
      end
    end
    chk({tag, ".busy"}, 64'(bus.busy), 64'(exp_busy));
  endtask

  initial begin
    rst_n = 1'b0;
    bus.req_valid   = '0;
    bus.req_addr    = '0;
    bus.req_data    = '0;
    bus.wb_stall    = 1'b0;
    bus.sb_set_en   = 1'b0;
    bus.sb_set_addr = '0;
    bus.sb_flush    = 1'b0;
    last_ok = 1'b1; last_a = '0; last_d = '0;
    for (int i = 0; i < 3; i++) set_req(i, '0, '0);

    // Reset state; ready held low in reset even with valid requests.
    set_req(0, 5'd1, 32'hA000_0001);
    set_req(1, 5'd2, 32'hB000_0002);
    set_req(2, 5'd3, 32'hC000_0003);
    bus.req_valid = 3'b111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.rd_we",   64'(bus.rd_we),     64'(0));
    chk("rst.rd_addr", 64'(bus.rd_addr),   64'(0));
    chk("rst.rd_data", 64'(bus.rd_data),   64'(0));
    chk("rst.busy",    64'(bus.busy),      64'(0));
    chk("rst.ready",   64'(bus.req_ready), 64'(0));
    rst_n = 1'b1;

    // T3: round robin from reset
    do_cycle("rr0", 3'b001, 32'h0);
    do_cycle("rr1", 3'b010, 32'h0);
    do_cycle("rr2", 3'b100, 32'h0);
    do_cycle("rr3", 3'b001, 32'h0);
    do_cycle("rr4", 3'b010, 32'h0);
    do_cycle("rr5", 3'b100, 32'h0);

    // T2: single request
    bus.req_valid = 3'b010;
    set_req(1, 5'd5, 32'hDEAD_BEEF);
    do_cycle("single", 3'b010, 32'h0);

    // T4: write to x0 accepted but dropped, pointer wraps to 0
    bus.req_valid = 3'b100;
    set_req(2, 5'd0, 32'h0000_1234);
    do_cycle("x0", 3'b100, 32'h0);

    // T5: stall holds off grants and the pointer
    bus.req_valid = 3'b111;
    set_req(2, 5'd3, 32'hC000_0033);
    bus.wb_stall = 1'b1;
    do_cycle("stall0", 3'b000, 32'h0);
    do_cycle("stall1", 3'b000, 32'h0);
    do_cycle("stall2", 3'b000, 32'h0);
    bus.wb_stall = 1'b0;
    do_cycle("unstall0", 3'b001, 32'h0);
    do_cycle("unstall1", 3'b010, 32'h0);

    // T6: scoreboard
    bus.req_valid   = 3'b000;
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 5'd7;
    do_cycle("sb_set7", 3'b000, 32'h0000_0080);
    bus.req_valid = 3'b001;
    set_req(0, 5'd7, 32'h7777_0007);
    do_cycle("sb_setclr7", 3'b001, 32'h0000_0080);
    bus.sb_set_en = 1'b0;
    set_req(0, 5'd7, 32'h7777_0008);
    do_cycle("sb_clr7", 3'b001, 32'h0);
    bus.req_valid   = 3'b000;
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 5'd0;
    do_cycle("sb_set0", 3'b000, 32'h0);
    exp_b = 32'h0;
    for (int r = 4; r < 16; r++) begin
      if (r == 8) r = 12;
      bus.sb_set_addr = 5'(r);
      exp_b[r] = 1'b1;
      do_cycle("sb_fill", 3'b000, exp_b);
    end
    chk("sb_F0F0", 64'(bus.busy), 64'(32'h0000_F0F0));
    bus.sb_set_en = 1'b0;
    bus.sb_flush  = 1'b1;
    do_cycle("sb_flush", 3'b000, 32'h0);
    bus.sb_flush    = 1'b0;
    bus.sb_set_en   = 1'b1;
    bus.sb_set_addr = 5'd3;
    do_cycle("sb_set3", 3'b000, 32'h0000_0008);
    bus.sb_flush    = 1'b1;
    bus.sb_set_addr = 5'd9;
    do_cycle("sb_flushset9", 3'b000, 32'h0000_0200);
    bus.sb_flush  = 1'b0;
    bus.sb_set_en = 1'b0;

    // T1: asynchronous reset while a transfer is in flight
    bus.req_valid = 3'b010;
    set_req(1, 5'd4, 32'h4444_0004);
    do_cycle("pre_rst", 3'b010, 32'h0000_0200);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.rd_we", 64'(bus.rd_we),     64'(0));
    chk("arst.busy",  64'(bus.busy),      64'(0));
    chk("arst.ready", 64'(bus.req_ready), 64'(0));
    q.delete();
    last_ok = 1'b1; last_a = '0; last_d = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.req_valid = 3'b111;
    set_req(1, 5'd4, 32'h4444_0005);
    do_cycle("post_rst", 3'b001, 32'h0);
    do_cycle("post_rst1", 3'b010, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
